// File: rtl/parking_lane_counter_if.sv
// parking_lane_counter_if: sensor beams and clear in, lane events and occupancy out.
// Optional macro DECIMAL_DISPLAY_EN adds the count_bcd display field.
interface parking_lane_counter_if #(
    parameter int LANES = 2,
    parameter int CNT_W = 8
);
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic             clear;
    logic [LANES-1:0] enter_tick;
    logic [LANES-1:0] exit_tick;
    logic [LANES-1:0] err;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef DECIMAL_DISPLAY_EN
    logic [11:0]      count_bcd;

    modport master (
        output a, b, clear,
        input  enter_tick, exit_tick, err, count, full, empty, count_bcd
    );
    modport slave (
        input  a, b, clear,
        output enter_tick, exit_tick, err, count, full, empty, count_bcd
    );
`else
    modport master (
        output a, b, clear,
        input  enter_tick, exit_tick, err, count, full, empty
    );
    modport slave (
        input  a, b, clear,
        output enter_tick, exit_tick, err, count, full, empty
    );
`endif
endinterface

// File: rtl/parking_lane_counter.sv
// parking_lane_counter: multi-lane parking occupancy counter.
// Each lane: 2-FF synchroniser -> debouncer -> entry/exit direction FSM.
// Lane events feed one shared saturating occupancy register with full/empty flags.
// Optional macro DECIMAL_DISPLAY_EN adds a registered three-digit BCD copy of count.

// One sensor lane: raw beams in, single-cycle completion/error events out (combinational,
// registered by the top so ticks and the count move on the same edge).
module parking_lane_counter_lane #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic clear,
    output logic enter_ev,
    output logic exit_ev,
    output logic err_ev
);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, BAD
    } state_t;

    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    cand_q, cand_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [1:0]    pair_q, pair_d;
    state_t        state_q, state_d;

    // Debounce: a new synchronised pair must hold DEB_CYCLES cycles before it is accepted;
    // any change restarts the run length.
    always_comb begin
        sync1_d = {a_raw, b_raw};
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = DW'(1);
        end else if (cnt_q != DW'(DEB_CYCLES)) begin
            cnt_d = cnt_q + DW'(1);
        end
        if (cnt_d == DW'(DEB_CYCLES))
            pair_d = cand_d;
    end

    // Input path registers; counter starts saturated so the idle 00 pair is already stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            cand_q  <= 2'b00;
            cnt_q   <= DW'(DEB_CYCLES);
            pair_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
        end
    end

    // Direction decode on the debounced pair {a,b}; OUT* mirror IN* with a/b swapped.
    always_comb begin
        state_d  = state_q;
        enter_ev = 1'b0;
        exit_ev  = 1'b0;
        err_ev   = 1'b0;
        case (state_q)
            IDLE: case (pair_q)
                2'b10:   state_d = IN1;
                2'b01:   state_d = OUT1;
                2'b11:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            IN1: case (pair_q)
                2'b11:   state_d = IN2;
                2'b00:   state_d = IDLE;
                2'b01:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            IN2: case (pair_q)
                2'b01:   state_d = IN3;
                2'b10:   state_d = IN1;
                2'b00:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            IN3: case (pair_q)
                2'b00:   begin state_d = IDLE; enter_ev = 1'b1; end
                2'b11:   state_d = IN2;
                2'b10:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            OUT1: case (pair_q)
                2'b11:   state_d = OUT2;
                2'b00:   state_d = IDLE;
                2'b10:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            OUT2: case (pair_q)
                2'b10:   state_d = OUT3;
                2'b01:   state_d = OUT1;
                2'b00:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            OUT3: case (pair_q)
                2'b00:   begin state_d = IDLE; exit_ev = 1'b1; end
                2'b11:   state_d = OUT2;
                2'b01:   begin state_d = BAD; err_ev = 1'b1; end
                default: ;
            endcase
            BAD: if (pair_q == 2'b00) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // clear wins over any transition and swallows this cycle's events
        if (clear) begin
            state_d  = IDLE;
            enter_ev = 1'b0;
            exit_ev  = 1'b0;
            err_ev   = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
endmodule

module parking_lane_counter #(
    parameter int LANES      = 2,
    parameter int CNT_W      = 8,
    parameter int CAPACITY   = 200,
    parameter int DEB_CYCLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    parking_lane_counter_if.slave bus
);
    localparam int SW = CNT_W + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    if (CAPACITY >= 2 ** CNT_W) begin : g_cap_chk
        $error("CAPACITY must fit in CNT_W bits");
    end
    if (DEB_CYCLES < 1) begin : g_deb_chk
        $error("DEB_CYCLES must be at least 1");
    end

    logic [LANES-1:0] a_raw, b_raw;
    logic [LANES-1:0] enter_ev, exit_ev, err_ev;
    logic [LANES-1:0] enter_q, exit_q, err_q;

    logic signed [SW-1:0] n_ent, n_ext, sum;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;

    assign a_raw = bus.a;
    assign b_raw = bus.b;

    parking_lane_counter_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane [LANES-1:0] (
        .clk      (clk),
        .reset    (reset),
        .a_raw    (a_raw),
        .b_raw    (b_raw),
        .clear    (bus.clear),
        .enter_ev (enter_ev),
        .exit_ev  (exit_ev),
        .err_ev   (err_ev)
    );

    // Net lane events applied to the count with a signed clamp to [0, CAPACITY];
    // flags follow the clamped value so they match count on the same edge.
    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            n_ent = n_ent + {{(SW-1){1'b0}}, enter_ev[i]};
            n_ext = n_ext + {{(SW-1){1'b0}}, exit_ev[i]};
        end
        sum = $signed({2'b00, count_q}) + n_ent - n_ext;
        if (bus.clear)
            count_d = '0;
        else if (sum < 0)
            count_d = '0;
        else if (sum > CAP_S)
            count_d = CNT_W'(CAPACITY);
        else
            count_d = sum[CNT_W-1:0];
        full_d  = (count_d == CNT_W'(CAPACITY));
        empty_d = (count_d == '0);
    end

    // Occupancy, flags and registered lane pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            enter_q <= '0;
            exit_q  <= '0;
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            enter_q <= enter_ev;
            exit_q  <= exit_ev;
            err_q   <= err_ev;
        end
    end

    assign bus.enter_tick = enter_q;
    assign bus.exit_tick  = exit_q;
    assign bus.err        = err_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;

`ifdef DECIMAL_DISPLAY_EN
    if (CAPACITY > 999) begin : g_bcd_chk
        $error("CAPACITY must be <= 999 for the BCD display");
    end

    logic [11:0] count_bcd_q, count_bcd_d;

    // Shift-and-add-3 binary to BCD; values never exceed CAPACITY so three digits suffice.
    function automatic logic [11:0] to_bcd(input logic [CNT_W-1:0] v);
        logic [11:0] r;
        r = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 3; d++)
                if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            r = {r[10:0], v[i]};
        end
        return r;
    endfunction

    // Convert the already-registered count, so the display trails count by one cycle.
    always_comb begin
        count_bcd_d = to_bcd(count_q);
    end

    // Display register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_bcd_q <= '0;
        else        count_bcd_q <= count_bcd_d;
    end

    assign bus.count_bcd = count_bcd_q;
`endif
endmodule

// File: tb/tb_parking_lane_counter.sv
// Directed bench for parking_lane_counter: LANES=2, CAPACITY=3, DEB_CYCLES=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_parking_lane_counter;
    localparam int LANES = 2;
    localparam int CNT_W = 8;
    localparam int CAP   = 3;
    localparam int DEB   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_lane_counter_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

    parking_lane_counter #(
        .LANES(LANES), .CNT_W(CNT_W), .CAPACITY(CAP), .DEB_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int ent_n [LANES];
    int ext_n [LANES];
    int err_n [LANES];

    // pulse tallies, settled well before the next falling-edge check
    initial for (int i = 0; i < LANES; i++) begin ent_n[i] = 0; ext_n[i] = 0; err_n[i] = 0; end
    always @(posedge clk) begin
        #1;
        if (reset)
            for (int i = 0; i < LANES; i++) begin
                ent_n[i] += int'(bus.enter_tick[i]);
                ext_n[i] += int'(bus.exit_tick[i]);
                err_n[i] += int'(bus.err[i]);
            end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // av/bv are {lane1, lane0}
    task automatic hold(input logic [1:0] av, input logic [1:0] bv, input int n);
        bus.a = av;
        bus.b = bv;
        cyc(n);
    endtask

    // Apply the closing pair and check the tick lands exactly on edge DEB+3.
    task automatic finish_chk(input string tag, input logic [1:0] av, input logic [1:0] bv,
                              input logic [1:0] exp_ent, input logic [1:0] exp_ext,
                              input int prev_cnt, input int exp_cnt);
        hold(av, bv, DEB + 2);
        chk({tag, " pre ticks"}, {bus.enter_tick, bus.exit_tick}, 0);
        chk({tag, " pre count"}, bus.count, prev_cnt);
        cyc(1);
        chk({tag, " enter"}, bus.enter_tick, exp_ent);
        chk({tag, " exit"}, bus.exit_tick, exp_ext);
        chk({tag, " count"}, bus.count, exp_cnt);
        cyc(1);
        chk({tag, " post ticks"}, {bus.enter_tick, bus.exit_tick}, 0);
        cyc(3);
    endtask

    initial begin
        reset = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.clear = 1'b0;
        cyc(3);
        chk("rst count", bus.count, 0);
        chk("rst empty", bus.empty, 1);
        chk("rst full", bus.full, 0);
        chk("rst pulses", {bus.enter_tick, bus.exit_tick, bus.err}, 0);
        reset = 1'b1;
        cyc(6);

        // lane0 entry 10,11,01,00
        hold(2'b01, 2'b00, 4);
        hold(2'b01, 2'b01, 4);
        hold(2'b00, 2'b01, 4);
        finish_chk("ent0", 2'b00, 2'b00, 2'b01, 2'b00, 0, 1);
        chk("ent0 empty", bus.empty, 0);
        chk("ent0 once", ent_n[0], 1);

        // lane1 exit 01,11,10,00 at count 1, then again at count 0
        hold(2'b00, 2'b10, 4);
        hold(2'b10, 2'b10, 4);
        hold(2'b10, 2'b00, 4);
        finish_chk("ext1", 2'b00, 2'b00, 2'b00, 2'b10, 1, 0);
        chk("ext1 empty", bus.empty, 1);
        hold(2'b00, 2'b10, 4);
        hold(2'b10, 2'b10, 4);
        hold(2'b10, 2'b00, 4);
        finish_chk("ext1 floor", 2'b00, 2'b00, 2'b00, 2'b10, 0, 0);
        chk("ext1 total", ext_n[1], 2);

        // lane0 backtrack then abort: 10,11,10,00
        hold(2'b01, 2'b00, 4);
        hold(2'b01, 2'b01, 4);
        hold(2'b01, 2'b00, 4);
        hold(2'b00, 2'b00, 8);
        chk("abort enter", ent_n[0], 1);
        chk("abort err", err_n[0], 0);
        chk("abort count", bus.count, 0);

        // lane0 00->11 is illegal; BAD must ride out 01 and 10 without a second error
        hold(2'b01, 2'b01, 8);
        chk("bad err", err_n[0], 1);
        hold(2'b00, 2'b01, 6);
        hold(2'b01, 2'b00, 6);
        hold(2'b00, 2'b00, 6);
        chk("bad held", err_n[0], 1);
        chk("bad exits", ext_n[0], 0);

        // one-cycle glitch on a[0] in IDLE
        hold(2'b01, 2'b00, 1);
        hold(2'b00, 2'b00, 8);
        chk("glitch idle err", err_n[0], 1);
        chk("glitch idle ent", ent_n[0], 1);

        // lane0 exit to OUT3 (10), glitch a low for one cycle: must not complete
        hold(2'b00, 2'b01, 4);
        hold(2'b01, 2'b01, 4);
        hold(2'b01, 2'b00, 4);
        hold(2'b00, 2'b00, 1);
        hold(2'b01, 2'b00, 8);
        chk("glitch out3", ext_n[0], 0);
        finish_chk("ext0", 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        chk("ext0 total", ext_n[0], 1);

        // simultaneous entries: 0->2, then 2->3 (clamped), full
        hold(2'b11, 2'b00, 4);
        hold(2'b11, 2'b11, 4);
        hold(2'b00, 2'b11, 4);
        finish_chk("both 0", 2'b00, 2'b00, 2'b11, 2'b00, 0, 2);
        chk("both 0 full", bus.full, 0);
        hold(2'b11, 2'b00, 4);
        hold(2'b11, 2'b11, 4);
        hold(2'b00, 2'b11, 4);
        finish_chk("both 2", 2'b00, 2'b00, 2'b11, 2'b00, 2, 3);
        chk("both 2 full", bus.full, 1);

        // lane0 enter with lane1 exit at full: net zero
        hold(2'b01, 2'b10, 4);
        hold(2'b11, 2'b11, 4);
        hold(2'b10, 2'b01, 4);
        finish_chk("mix", 2'b00, 2'b00, 2'b01, 2'b10, 3, 3);
        chk("mix full", bus.full, 1);

        // clear on the same edge lane0 would complete an entry
        hold(2'b01, 2'b00, 4);
        hold(2'b01, 2'b01, 4);
        hold(2'b00, 2'b01, 4);
        hold(2'b00, 2'b00, DEB + 2);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("clear tick", bus.enter_tick, 0);
        chk("clear count", bus.count, 0);
        chk("clear empty", bus.empty, 1);
        chk("clear full", bus.full, 0);
        cyc(4);
        chk("clear ent total", ent_n[0], 4);

        // lane1 entry to 1, then reset while lane0 sits in IN2
        hold(2'b10, 2'b00, 4);
        hold(2'b10, 2'b10, 4);
        hold(2'b00, 2'b10, 4);
        finish_chk("ent1", 2'b00, 2'b00, 2'b10, 2'b00, 0, 1);
        hold(2'b01, 2'b00, 4);
        hold(2'b01, 2'b01, 6);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async count", bus.count, 0);
        chk("async empty", bus.empty, 1);
        cyc(2);
        reset = 1'b1;
        hold(2'b00, 2'b01, 6);
        hold(2'b00, 2'b00, 8);
        chk("post rst ent", ent_n[0], 4);
        chk("post rst ext", ext_n[0], 1);
        chk("post rst err", err_n[0], 1);
        chk("post rst count", bus.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/parking_lane_counter.md
Name: parking_lane_counter

Overview:
- Multi-lane parking occupancy counter. Each lane has a two-beam sensor pair (a outer, b inner).
- A per-lane direction FSM decodes complete entry and exit sequences.
- A shared saturating occupancy register is updated from all lane events, with full/empty flags.
- Sits between the sensor input pins and the display/gate logic. Replaces the single-lane fsm.

Parameters:
LANES, 2, number of independent sensor pairs
CNT_W, 8, occupancy counter width
CAPACITY, 200, maximum occupancy (must be < 2^CNT_W)
DEB_CYCLES, 4, consecutive stable cycles required before a sensor pair change is accepted (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
a  in  LANES  outer beam per lane, raw/asynchronous, 1 = blocked
b  in  LANES  inner beam per lane, raw/asynchronous, 1 = blocked
clear  in  1  synchronous: count <= 0, all lane FSMs to IDLE
enter_tick  out  LANES  one-cycle pulse per completed entry
exit_tick  out  LANES  one-cycle pulse per completed exit
err  out  LANES  one-cycle pulse on illegal sequence
count  out  CNT_W  current occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0

Behaviour:
- Reset (reset=0, asynchronous) sets all outputs to: count=0, empty=1, full=0, ticks=0, err=0. Sync flops, debounce counters and FSMs are cleared, and each lane's debounced pair is set to 00.
- Per-lane input path: 2-FF synchroniser on {a,b}, then a debouncer. The debounced pair updates only after the synchronised pair has held one new value for DEB_CYCLES consecutive cycles; any change restarts the count.
- Per-lane FSM, clocked on the debounced pair p={a,b}:
  - IDLE: 10->IN1; 01->OUT1; 11->BAD, err pulse; 00 stay.
  - IN1: 11->IN2; 00->IDLE (abort, no tick); 01->BAD, err.
  - IN2: 01->IN3; 10->IN1 (backtrack); 00->BAD, err.
  - IN3: 00->IDLE + enter_tick; 11->IN2; 10->BAD, err.
  - OUT1/OUT2/OUT3 mirror IN1..IN3 with a and b swapped; OUT3 on 00 gives exit_tick.
  - BAD: stays until p==00, then IDLE.
- Latency: a raw edge that completes a sequence produces its tick and count update at clock edge DEB_CYCLES+3 after the edge is first sampled.
- Occupancy update, all lanes in the same cycle:
  - net = popcount(enter_tick) - popcount(exit_tick).
  - count_next = clamp(count+net, 0, CAPACITY), computed with internal width CNT_W+2 signed.
  - Ticks are still emitted when saturated; the clamp silently absorbs the excess.
- full and empty are registered and consistent with count in the same cycle.
- clear has priority over lane events in the same cycle. Ticks in that cycle are suppressed.
- Reset mid-sequence abandons the sequence; no tick after release.

Optional Feature:
- Macro DECIMAL_DISPLAY_EN.
- When defined: adds output count_bcd [11:0] (three BCD digits, hundreds:tens:units), registered one cycle after count. Reset value 0. CAPACITY must be <=999, checked by a generate-time error.
- When undefined: the port and its conversion logic are absent. All other behaviour is unchanged.

Test Plan:
- All tests use LANES=2, CAPACITY=3, DEB_CYCLES=2.
- Lane0 drives 00,10,11,01,00, each held 4 cycles -> enter_tick[0] pulses once, exactly 5 cycles after 00 is applied; count 0->1, empty 1->0.
- Lane1 drives 00,01,11,10,00 with count=1 -> exit_tick[1] once; count=0, empty=1. A further exit at count=0 -> tick pulses, count stays 0.
- Lane0 drives 10,11,10,00 (backtrack then abort) -> no tick, count unchanged. Lane0 drives 00->11 -> err[0] pulse; state held until 00 is seen.
- Glitch on a[0] of 1 cycle -> ignored, FSM stays IDLE.
- Simultaneous entries on both lanes at count=2 -> both ticks pulse; count=3, full=1. A simultaneous enter on lane0 and exit on lane1 at count=3 -> count stays 3.
- reset low while lane0 is in IN2 -> count=0 immediately (asynchronous). Completing the rest of the sequence after release gives no tick. With DECIMAL_DISPLAY_EN and CAPACITY=200, 127 entries -> count_bcd=12'h127 one cycle after count=127.
